jimmy_core: RTL and testbench
=============================

Name: jimmy_core

Overview:
- 8-bit single-issue teaching CPU for the Jimmy project.
- Fetches 8-bit instruction bytes from an external program ROM over an 8-bit address/data pair.
- Executes on four 8-bit general registers.
- Talks to the outside world through four input ports and four strobed output ports.
- Top-level boards and benches pair it with a program ROM module, for example a factorial program that reads port 0 and writes port 1.

Parameters:
- RESET_VECTOR, 8'h00, PC value loaded on reset.

Ports:
- jimmy_clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_address_bus  out  8  program counter, driven straight from the PC register.
- inst_data_bus  in  8  instruction/immediate byte. The ROM is treated as combinational: the byte is valid in the same cycle its address is presented.
- in_port_0..in_port_3  in  8 each  input ports.
- out_port_0..out_port_3  out  8 each  registered output ports.
- out_strobe  out  4  bit k pulses high for one cycle when out_port_k is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC = RESET_VECTOR.
  - R0..R3 = 0; flags Z and C = 0.
  - All out_port_k = 0; out_strobe = 0.
  - state = FETCH; halted = 0.
  - Asserting reset mid-instruction, including in the IMM state, aborts the instruction with no register or port write.
- Encoding: op = inst[7:4], rd = inst[3:2], rs = inst[1:0].
- States:
  - FETCH: decode the byte at PC and execute single-byte ops; PC <= PC+1. Two-byte ops go to IMM.
  - IMM: the byte at PC (already incremented) is the operand. Execute, then PC <= PC+1 or the jump target, and return to FETCH.
- Opcodes:
  - 0x0 MOV rd<=rs.
  - 0x1 ADD rd<=rd+rs; C = carry out.
  - 0x2 SUB rd<=rd-rs; C = borrow.
  - 0x3 AND, 0x4 OR, 0x5 XOR: C = 0.
  - 0x6 SHL rd: C = rd[7]. 0x7 SHR rd: logical, C = rd[0]. rs ignored for both.
  - 0x8 LDI rd,#imm (2 bytes): flags unchanged.
  - 0x9 IN rd,port rs: rd <= in_port_rs, sampled at the clock edge; flags unchanged.
  - 0xA OUT port rd, rs: out_port_rd <= Rrs; out_strobe[rd] = 1 for exactly the following cycle. Port data stays stable until the next OUT to the same port.
  - 0xB JMP addr, 0xC JZ addr, 0xD JNZ addr, 0xE JC addr (2 bytes): jump not taken means execution continues at the byte after the operand.
  - 0xF misc: 0xF0 = NOP; every other 0xFx = NOP, except as described under Optional Feature.
- Flag update: ALU ops (0x1–0x7) set Z = (result==0). MOV, IN, OUT, LDI and jumps leave the flags unchanged.
- Arithmetic is modulo 256.
- PC wraps from 0xFF to 0x00.
- Reading the register being written in the same op uses the old value.
- Multiple strobe bits are never active at once; each OUT produces a one-cycle pulse.
- Throughput: single-byte ops take 1 cycle; two-byte ops take 2 cycles.

Optional Feature:
- Macro JIMMY_HALT_EN.
- When defined, 0xFF = HALT: PC freezes, no further fetch execution, outputs hold their values; only reset clears the halt.
- When undefined, 0xFF executes as NOP and there is no halted state.

Test Plan:
- Reset: hold reset=0 for 5 cycles, then release -> inst_address_bus=0x00, all out ports 0x00, out_strobe=0. The first fetch occurs at address 0x00.
- LDI/OUT: run LDI R1,#0x5A; OUT 1,R1 -> out_port_1=0x5A; out_strobe=4'b0010 for exactly one cycle, starting 3 cycles after release.
- ADD carry and jumps:
  - LDI R0,#0xFF; LDI R1,#1; ADD R0,R1 -> R0=0x00, Z=1, C=1.
  - A following JZ is taken and JNZ is not; PC values checked in each case.
- Factorial program:
  - Bench increments in_port_0 on each falling edge of out_strobe[1], starting at 0.
  - Required sequence on out_port_1: 1,1,2,6,24,120, then 720 mod 256 = 0xD0.
- Mid-instruction reset: assert reset during the IMM cycle of LDI -> destination register stays 0, and PC=0 on release.
- HALT: with JIMMY_HALT_EN, 0xFF at address 3 -> PC stays at 4 with no further strobes. Without the macro, execution continues past 0xFF.

Source files
------------

// File: rtl/jimmy_core.sv
// jimmy_core: 8-bit teaching CPU with four registers, four input ports and four strobed output ports.
// Define JIMMY_HALT_EN to make 0xFF a HALT that freezes the core until reset.
module jimmy_core #(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic       jimmy_clk,
  input  logic       reset,
  output logic [7:0] inst_address_bus,
  input  logic [7:0] inst_data_bus,
  input  logic [7:0] in_port_0,
  input  logic [7:0] in_port_1,
  input  logic [7:0] in_port_2,
  input  logic [7:0] in_port_3,
  output logic [7:0] out_port_0,
  output logic [7:0] out_port_1,
  output logic [7:0] out_port_2,
  output logic [7:0] out_port_3,
  output logic [3:0] out_strobe
);

`ifdef JIMMY_HALT_EN
  typedef enum logic [1:0] {FETCH, IMM, HALTED} state_t;
`else
  typedef enum logic [0:0] {FETCH, IMM} state_t;
`endif

  typedef enum logic [3:0] {
    OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_LDI = 4'h8, OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JNZ = 4'hD, OP_JC  = 4'hE, OP_MISC = 4'hF
  } opcode_t;

  state_t     state, state_d;
  logic [7:0] pc, pc_d;
  logic [5:0] ir, ir_d;              // opcode and rd of a two-byte op, held across IMM
  logic       z, z_d, c, c_d;
  logic [7:0] regs [4];
  logic [7:0] regs_d [4];
  logic [7:0] port_q [4];
  logic [7:0] port_d [4];
  logic [3:0] strobe_q, strobe_d;
  logic [7:0] in_bus [4];

  opcode_t    f_op, i_op;
  logic [1:0] f_rd, f_rs, i_rd;
  logic [7:0] a, b;
  logic [8:0] alu;

  assign in_bus[0] = in_port_0;
  assign in_bus[1] = in_port_1;
  assign in_bus[2] = in_port_2;
  assign in_bus[3] = in_port_3;

  assign f_op = opcode_t'(inst_data_bus[7:4]);
  assign f_rd = inst_data_bus[3:2];
  assign f_rs = inst_data_bus[1:0];
  assign i_op = opcode_t'(ir[5:2]);
  assign i_rd = ir[1:0];
  assign a    = regs[f_rd];
  assign b    = regs[f_rs];

  // Bit 8 of alu is the carry/borrow; SUB's ninth bit is set exactly when a < b.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    alu = 9'd0;
    case (f_op)
      OP_ADD:  alu = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu = {1'b0, a} - {1'b0, b};
      OP_AND:  alu = {1'b0, a & b};
      OP_OR:   alu = {1'b0, a | b};
      OP_XOR:  alu = {1'b0, a ^ b};
      OP_SHL:  alu = {a[7], a[6:0], 1'b0};
      OP_SHR:  alu = {a[0], 1'b0, a[7:1]};
      default: alu = 9'd0;
    endcase
  end

  always_comb begin
    state_d  = FETCH;
    pc_d     = pc + 8'd1;
    ir_d     = ir;
    z_d      = z;
    c_d      = c;
    regs_d   = regs;
    port_d   = port_q;
    strobe_d = 4'b0000;
    case (state)
      FETCH: begin
        ir_d = inst_data_bus[7:2];
        case (f_op)
          OP_MOV: regs_d[f_rd] = b;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            regs_d[f_rd] = alu[7:0];
            z_d          = (alu[7:0] == 8'd0);
            c_d          = alu[8];
          end
          OP_LDI, OP_JMP, OP_JZ, OP_JNZ, OP_JC: state_d = IMM;
          OP_IN:  regs_d[f_rd] = in_bus[f_rs];
          OP_OUT: begin
            port_d[f_rd]   = b;
            strobe_d[f_rd] = 1'b1;
          end
          default: begin
`ifdef JIMMY_HALT_EN
            if (inst_data_bus == 8'hFF) state_d = HALTED;
`endif
          end
        endcase
      end
      IMM: begin
        case (i_op)
          OP_LDI:  regs_d[i_rd] = inst_data_bus;
          OP_JMP:  pc_d = inst_data_bus;
          OP_JZ:   if (z)  pc_d = inst_data_bus;
          OP_JNZ:  if (!z) pc_d = inst_data_bus;
          OP_JC:   if (c)  pc_d = inst_data_bus;
          default: ;
        endcase
      end
`ifdef JIMMY_HALT_EN
      HALTED: begin
        state_d = HALTED;
        pc_d    = pc;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge jimmy_clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= RESET_VECTOR;
      ir       <= '0;
      z        <= 1'b0;
      c        <= 1'b0;
      strobe_q <= 4'b0000;
      // NOTE: the register file is only four entries, so it is reset like any other flop rather than left as uninitialised memory.
      for (int i = 0; i < 4; i++) begin
        regs[i]   <= 8'd0;
        port_q[i] <= 8'd0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state    <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      z        <= z_d;
      c        <= c_d;
      strobe_q <= strobe_d;
      regs     <= regs_d;
      port_q   <= port_d;
    end
  end

  assign inst_address_bus = pc;
  assign out_port_0       = port_q[0];
  assign out_port_1       = port_q[1];
  assign out_port_2       = port_q[2];
  assign out_port_3       = port_q[3];
  assign out_strobe       = strobe_q;

endmodule

// File: tb/tb_jimmy_core.sv
// Self-checking bench for jimmy_core: ALU vector table, directed timing/corner sequences,
// the factorial program, and random programs checked against an instruction-level model.
module tb_jimmy_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] inst_address_bus, inst_data_bus;
  logic [7:0] in_p [4];
  logic [7:0] out_port_0, out_port_1, out_port_2, out_port_3;
  logic [3:0] out_strobe;
  logic [7:0] rom [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign inst_data_bus = rom[inst_address_bus];

  jimmy_core dut (
    .jimmy_clk        (clk),
    .reset            (reset),
    .inst_address_bus (inst_address_bus),
    .inst_data_bus    (inst_data_bus),
    .in_port_0        (in_p[0]),
    .in_port_1        (in_p[1]),
    .in_port_2        (in_p[2]),
    .in_port_3        (in_p[3]),
    .out_port_0       (out_port_0),
    .out_port_1       (out_port_1),
    .out_port_2       (out_port_2),
    .out_port_3       (out_port_3),
    .out_strobe       (out_strobe)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [7:0] m_pc, m_r [4], m_port [4];
  logic [3:0] m_strobe;
  logic       m_z, m_c, m_halt;

  task automatic model_reset();
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_strobe = 4'b0;
    for (int i = 0; i < 4; i++) begin m_r[i] = 8'h00; m_port[i] = 8'h00; end
  endtask

  task automatic model_step(output int cyc);
    logic [7:0] ins, imm, p1;
    logic [1:0] d, s;
    int         av, bv, res;
    logic       is_alu, take;
    m_strobe = 4'b0; cyc = 1;
    if (m_halt) return;
    ins = rom[m_pc]; d = ins[3:2]; s = ins[1:0];
    av = int'(m_r[d]); bv = int'(m_r[s]);
    p1 = m_pc + 8'd1; imm = rom[p1];
    is_alu = 1'b1; res = 0; take = 1'b0;
    case (ins[7:4])
      4'h1: begin res = av + bv; m_c = (res > 255); end
      4'h2: begin res = av - bv; m_c = (av < bv); end
      4'h3: begin res = av & bv; m_c = 1'b0; end
      4'h4: begin res = av | bv; m_c = 1'b0; end
      4'h5: begin res = av ^ bv; m_c = 1'b0; end
      4'h6: begin res = av * 2;  m_c = (av >= 128); end
      4'h7: begin res = av / 2;  m_c = (av % 2 == 1); end
      default: is_alu = 1'b0;
    endcase
    if (is_alu) begin
      m_r[d] = 8'(res);
      m_z = ((res & 255) == 0);
      m_pc = p1;
    end else begin
      case (ins[7:4])
        4'h0: m_r[d] = m_r[s];
        4'h9: m_r[d] = in_p[s];
        4'hA: begin m_port[d] = m_r[s]; m_strobe[d] = 1'b1; end
        4'hF: begin
`ifdef JIMMY_HALT_EN
          if (ins == 8'hFF) m_halt = 1'b1;
`endif
        end
        default: ;
      endcase
      m_pc = p1;
      if (ins[7:4] == 4'h8 || ins[7:4] >= 4'hB && ins[7:4] <= 4'hE) begin
        cyc = 2;
        case (ins[7:4])
          4'h8: m_r[d] = imm;
          4'hB: take = 1'b1;
          4'hC: take = m_z;
          4'hD: take = !m_z;
          4'hE: take = m_c;
          default: ;
        endcase
        m_pc = take ? imm : p1 + 8'd1;
      end
    end
  endtask

  // ---------------- ALU vector table ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic       z, c;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] fact_exp [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic got;
    logic [7:0] exp_pc;

    for (int i = 0; i < 4; i++) in_p[i] = 8'h00;
    vecs[0]  = '{4'h1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{4'h1, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[2]  = '{4'h2, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1};
    vecs[3]  = '{4'h2, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{4'h3, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{4'h4, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{4'h5, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{4'h6, 8'h81, 8'h33, 8'h02, 1'b0, 1'b1};
    vecs[8]  = '{4'h7, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{4'h0, 8'h11, 8'h77, 8'h77, 1'b0, 1'b0};
    vecs[10] = '{4'h7, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{4'h1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    fact_exp = '{8'd1, 8'd1, 8'd2, 8'd6, 8'd24, 8'd120, 8'hD0};

    // Reset state and first fetch address.
    clear_rom();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pc", inst_address_bus, 8'h00);
    check("rst_strobe", {4'b0, out_strobe}, 8'h00);
    check("rst_p0", out_port_0, 8'h00);
    check("rst_p3", out_port_3, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    check("rel_pc", inst_address_bus, 8'h00);
    cycles(1);
    check("first_fetch_pc", inst_address_bus, 8'h01);

    // LDI R1,#5A ; OUT 1,R1 -> strobe on port 1 for exactly the third cycle.
    clear_rom();
    rom[0] = 8'h84; rom[1] = 8'h5A; rom[2] = 8'hA5;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      check("ldi_out_strobe", {4'b0, out_strobe}, (k == 3) ? 8'h02 : 8'h00);
      check("ldi_out_p1", out_port_1, (k >= 3) ? 8'h5A : 8'h00);
    end

    // Table: LDI R0,a ; LDI R1,b ; op R0,R1 ; OUT 0,R0 ; JZ 40 ; JC 60 / JC 50.
    foreach (vecs[v]) begin
      clear_rom();
      rom[0] = 8'h80; rom[1] = vecs[v].a;
      rom[2] = 8'h84; rom[3] = vecs[v].b;
      rom[4] = {vecs[v].op, 4'b0001};
      rom[5] = 8'hA0;
      rom[6] = 8'hC0; rom[7] = 8'h40;
      rom[8] = 8'hE0; rom[9] = 8'h60;
      rom[8'h40] = 8'hE0; rom[8'h41] = 8'h50;
      do_reset();
      cycles(10);
      exp_pc = vecs[v].z ? (vecs[v].c ? 8'h50 : 8'h42) : (vecs[v].c ? 8'h60 : 8'h0A);
      check($sformatf("vec%0d_result", v), out_port_0, vecs[v].res);
      check($sformatf("vec%0d_flags_pc", v), inst_address_bus, exp_pc);
    end

    // ADD carry, JZ taken, JNZ not taken, then OUT R0 and JC taken.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hFF; rom[2] = 8'h84; rom[3] = 8'h01; rom[4] = 8'h11;
    rom[5] = 8'hC0; rom[6] = 8'h20;
    rom[8'h20] = 8'hD0; rom[8'h21] = 8'h30; rom[8'h22] = 8'hA0;
    rom[8'h23] = 8'hE0; rom[8'h24] = 8'h40;
    do_reset();
    cycles(5);  check("add_pc", inst_address_bus, 8'h05);
    cycles(2);  check("jz_taken_pc", inst_address_bus, 8'h20);
    cycles(2);  check("jnz_not_taken_pc", inst_address_bus, 8'h22);
    cycles(1);  check("add_r0_zero", out_port_0, 8'h00);
    check("add_out_strobe", {4'b0, out_strobe}, 8'h01);
    cycles(2);  check("jc_taken_pc", inst_address_bus, 8'h40);

    // Mid-instruction reset during the IMM cycle of LDI R0,#AA.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hAA; rom[2] = 8'hA0;
    do_reset();
    cycles(1);
    check("imm_state_pc", inst_address_bus, 8'h01);
    reset = 1'b0;
    #1;
    check("async_rst_pc", inst_address_bus, 8'h00);
    cycles(1);
    rom[0] = 8'hA0;
    @(negedge clk);
    reset = 1'b1;
    check("imm_rst_rel_pc", inst_address_bus, 8'h00);
    cycles(1);
    check("imm_rst_r0", out_port_0, 8'h00);
    check("imm_rst_strobe", {4'b0, out_strobe}, 8'h01);

    // HALT at address 3.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h11; rom[2] = 8'hA0; rom[3] = 8'hFF;
    rom[4] = 8'hA4; rom[5] = 8'hB0; rom[6] = 8'h04;
    do_reset();
    cycles(4);
    check("halt_pc", inst_address_bus, 8'h04);
`ifdef JIMMY_HALT_EN
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      check("halt_frozen_pc", inst_address_bus, 8'h04);
      check("halt_no_strobe", {4'b0, out_strobe}, 8'h00);
    end
    check("halt_p0_hold", out_port_0, 8'h11);
`else
    cycles(1);
    check("nohalt_pc", inst_address_bus, 8'h05);
    check("nohalt_strobe", {4'b0, out_strobe}, 8'h02);
    check("nohalt_p1", out_port_1, 8'h11);
`endif

    // Factorial: read n from port 0, write n! to port 1, loop.
    clear_rom();
    rom[8'h00] = 8'h90;
    rom[8'h01] = 8'h84; rom[8'h02] = 8'h00;
    rom[8'h03] = 8'h88; rom[8'h04] = 8'h01;
    rom[8'h05] = 8'h40;
    rom[8'h06] = 8'hC0; rom[8'h07] = 8'h0D;
    rom[8'h08] = 8'h64; rom[8'h09] = 8'h16; rom[8'h0A] = 8'h22;
    rom[8'h0B] = 8'hB0; rom[8'h0C] = 8'h05;
    rom[8'h0D] = 8'h80; rom[8'h0E] = 8'h01;
    rom[8'h0F] = 8'h45;
    rom[8'h10] = 8'hC0; rom[8'h11] = 8'h1D;
    rom[8'h12] = 8'h88; rom[8'h13] = 8'h00;
    rom[8'h14] = 8'h0D;
    rom[8'h15] = 8'h18; rom[8'h16] = 8'h7C;
    rom[8'h17] = 8'hD0; rom[8'h18] = 8'h15;
    rom[8'h19] = 8'h02; rom[8'h1A] = 8'h74;
    rom[8'h1B] = 8'hB0; rom[8'h1C] = 8'h0F;
    rom[8'h1D] = 8'hA4;
    rom[8'h1E] = 8'hB0; rom[8'h1F] = 8'h00;
    in_p[0] = 8'h00;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
        cycles(1);
        if (out_strobe[1]) got = 1'b1;
      end
      check($sformatf("fact%0d_strobe_seen", k), {7'b0, got}, 8'h01);
      if (got) begin
        check($sformatf("fact%0d_value", k), out_port_1, fact_exp[k]);
        cycles(1);
        check($sformatf("fact%0d_pulse_width", k), {4'b0, out_strobe}, 8'h00);
        in_p[0] = in_p[0] + 8'd1;
      end
    end

    // Random programs against the instruction-level model.
    for (int prog = 0; prog < 3; prog++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) in_p[i] = 8'($urandom);
      do_reset();
      model_reset();
      for (int n = 0; n < 300; n++) begin
        model_step(cyc);
        cycles(cyc);
        check("rnd_pc", inst_address_bus, m_pc);
        check("rnd_strobe", {4'b0, out_strobe}, {4'b0, m_strobe});
        check("rnd_p0", out_port_0, m_port[0]);
        check("rnd_p1", out_port_1, m_port[1]);
        check("rnd_p2", out_port_2, m_port[2]);
        check("rnd_p3", out_port_3, m_port[3]);
        for (int i = 0; i < 4; i++) in_p[i] = 8'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
